// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide sequencer owning the HI/LO registers.
// A fixed-latency counter models the datapath delay, and the block raises a
// D-stage stall while an operation is pending.
// Optional feature: define MDU_DIV_EN to build the divider. Without it,
// DIV/DIVU act as no-ops and DIV_CYCLES is only range-checked.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        mdu_instr_D,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned CNT_W  = 4;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  tmp_hi, tmp_lo;
  logic               div_zero;
  logic               is_mul_c, is_div_c;
  logic [PROD_W-1:0]  prod_c;
  logic [DATA_W-1:0]  quo_c, rem_c;

  // Reject cycle counts that the 4-bit counter cannot represent.
  if (MULT_CYCLES == 0 || MULT_CYCLES > 15 || DIV_CYCLES == 0 || DIV_CYCLES > 15) begin : g_bad_cycles
    $error("mdu_ctrl: MULT_CYCLES and DIV_CYCLES must be in 1..15");
  end

  // 64-bit product; sign-extending both operands gives the signed product in the low 64 bits.
  always_comb begin
    prod_c = '0;
    if (op == OP_MULT)
      prod_c = {{DATA_W{src_a[DATA_W-1]}}, src_a} * {{DATA_W{src_b[DATA_W-1]}}, src_b};
    else
      prod_c = {{DATA_W{1'b0}}, src_a} * {{DATA_W{1'b0}}, src_b};
  end

`ifdef MDU_DIV_EN
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_DIVU = 3'd3;

  logic              div_sgn_c;
  logic [DATA_W-1:0] mag_a_c, mag_b_c, dvsr_c, quo_u_c, rem_u_c;

  // Sign-magnitude divide: truncating quotient, remainder follows the dividend's sign.
  always_comb begin
    div_sgn_c = (op == OP_DIV);
    mag_a_c   = (div_sgn_c && src_a[DATA_W-1]) ? -src_a : src_a;
    mag_b_c   = (div_sgn_c && src_b[DATA_W-1]) ? -src_b : src_b;
    dvsr_c    = (mag_b_c == '0) ? DATA_W'(1) : mag_b_c;
    quo_u_c   = mag_a_c / dvsr_c;
    rem_u_c   = mag_a_c % dvsr_c;
    quo_c     = (div_sgn_c && (src_a[DATA_W-1] ^ src_b[DATA_W-1])) ? -quo_u_c : quo_u_c;
    rem_c     = (div_sgn_c && src_a[DATA_W-1]) ? -rem_u_c : rem_u_c;
  end

  assign is_div_c = start && (op == OP_DIV || op == OP_DIVU);
`else
  assign quo_c    = '0;
  assign rem_c    = '0;
  assign is_div_c = 1'b0;
`endif

  assign is_mul_c = start && (op == OP_MULT || op == OP_MULTU);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: multiply/divide enter RUN, leave on the last counted cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (is_mul_c || is_div_c) state_nxt = RUN;
      RUN:  if (cnt == CNT_W'(1))     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    busy = 1'b0;
    if (state == RUN) busy = 1'b1;
  end

  // Hold D-stage MDU instructions while an op is being issued or is in flight.
  assign stall_md = mdu_instr_D & (start | busy);

  // Datapath: latch results on issue, count down, commit on the final edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt      <= '0;
      tmp_hi   <= '0;
      tmp_lo   <= '0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else if (state == IDLE) begin
      if (is_mul_c) begin
        tmp_hi   <= prod_c[PROD_W-1:DATA_W];
        tmp_lo   <= prod_c[DATA_W-1:0];
        div_zero <= 1'b0;
        cnt      <= CNT_W'(MULT_CYCLES);
      end else if (is_div_c) begin
        tmp_hi   <= rem_c;
        tmp_lo   <= quo_c;
        div_zero <= (src_b == '0);
        cnt      <= CNT_W'(DIV_CYCLES);
      end else if (start && op == OP_MTHI) begin
        hi <= src_a;
      end else if (start && op == OP_MTLO) begin
        lo <= src_a;
      end
    end else begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1) && !div_zero) begin
        hi <= tmp_hi;
        lo <= tmp_lo;
      end
    end
  end

endmodule
